// File: rtl/blake2_bus_host.sv
// blake2_bus_host: FPGA-side initiator/capture host for the blake2 PMOD byte bus.
// Drives command/data bytes onto the bus, gated by the emulator's synchronised
// ready, with a fixed idle gap after each byte. It also collects hash_v-qualified
// hash bytes into a framed output stream.
// Optional feature: define BLAKE2_BUS_HOST_TIMEOUT_EN to build the sticky
// ready-wait watchdog behind timeout_o. Without it, timeout_o is tied to 0.
module blake2_bus_host #(
   parameter int GAP_CYCLES = 4,
   parameter int HASH_BYTES = 32,
   parameter int TIMEOUT_W  = 16
) (
   input  logic       clk,
   input  logic       rst_async,
   input  logic       s_valid_i,
   output logic       s_ready_o,
   input  logic [1:0] s_cmd_i,
   input  logic [7:0] s_data_i,
   input  logic [1:0] loopback_i,
   output logic [7:0] data_o,
   output logic [2:0] data_ctrl_o,
   output logic [1:0] loopback_ctrl_o,
   input  logic [7:0] hash_i,
   input  logic [1:0] hash_ctrl_i,
   output logic       m_valid_o,
   output logic [7:0] m_data_o,
   output logic       m_last_o,
   output logic       short_hash_o,
   output logic       busy_o,
   output logic       timeout_o
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam int IDX_W = (HASH_BYTES > 1) ? $clog2(HASH_BYTES) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(HASH_BYTES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_GAP   = 2'd2
   } tx_state_t;

   tx_state_t        state_r;
   logic [GAP_W-1:0] gap_cnt_r;
   logic [IDX_W-1:0] idx_r;
   logic [7:0]       hash_meta_r;
   logic [7:0]       hash_sync_r;
   logic [1:0]       ctrl_meta_r;
   logic [1:0]       ctrl_sync_r;
   logic             rdy_s;
   logic             hv_s;
   logic             accept_s;

   assign rdy_s = ctrl_sync_r[0];
   assign hv_s  = ctrl_sync_r[1];

   // A byte is taken only while idle with the DUT reporting ready.
   assign accept_s  = (state_r == ST_IDLE) && s_valid_i && rdy_s;
   assign s_ready_o = accept_s;

   // Two-flop synchronisers for the bus signals coming back from the DUT.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         hash_meta_r <= 8'h00;
         hash_sync_r <= 8'h00;
         ctrl_meta_r <= 2'b00;
         ctrl_sync_r <= 2'b00;
      end else begin
         hash_meta_r <= hash_i;
         hash_sync_r <= hash_meta_r;
         ctrl_meta_r <= hash_ctrl_i;
         ctrl_sync_r <= ctrl_meta_r;
      end
   end

   // Loopback request is simply re-timed onto the bus every cycle.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         loopback_ctrl_o <= 2'b00;
      end else begin
         loopback_ctrl_o <= loopback_i;
      end
   end

   // Transmit FSM: latch an accepted byte, strobe valid for one cycle, then idle out the gap.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state_r     <= ST_IDLE;
         data_o      <= 8'h00;
         data_ctrl_o <= 3'b000;
         gap_cnt_r   <= '0;
         busy_o      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  data_o      <= s_data_i;
                  data_ctrl_o <= {s_cmd_i, 1'b1};
                  busy_o      <= 1'b1;
                  state_r     <= ST_DRIVE;
               end else begin
                  state_r     <= ST_IDLE;
               end
            end
            ST_DRIVE: begin
               // Data and cmd stay on the bus; only the valid strobe drops.
               data_ctrl_o[0] <= 1'b0;
               gap_cnt_r      <= GAP_LOAD;
               state_r        <= ST_GAP;
            end
            ST_GAP: begin
               if (gap_cnt_r == '0) begin
                  busy_o  <= 1'b0;
                  state_r <= ST_IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r - GAP_W'(1);
               end
            end
            default: begin
               data_ctrl_o[0] <= 1'b0;
               busy_o         <= 1'b0;
               state_r        <= ST_IDLE;
            end
         endcase
      end
   end

   // Hash capture: one output beat per synced hash_v cycle, framed by a wrapping byte index.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         m_valid_o    <= 1'b0;
         m_data_o     <= 8'h00;
         m_last_o     <= 1'b0;
         short_hash_o <= 1'b0;
         idx_r        <= '0;
      end else begin
         m_valid_o <= hv_s;
         if (hv_s) begin
            m_data_o     <= hash_sync_r;
            short_hash_o <= 1'b0;
            if (idx_r == IDX_LAST) begin
               m_last_o <= 1'b1;
               idx_r    <= '0;
            end else begin
               m_last_o <= 1'b0;
               idx_r    <= idx_r + IDX_W'(1);
            end
         end else begin
            // hash_v dropping part-way through a frame flags a truncated hash.
            m_last_o     <= 1'b0;
            short_hash_o <= (idx_r != '0);
            idx_r        <= '0;
         end
      end
   end

`ifdef BLAKE2_BUS_HOST_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wait_cnt_r;
   logic [TIMEOUT_W-1:0] wait_cnt_nxt_s;

   // Count consecutive idle cycles spent waiting on ready; saturate at all-ones.
   always_comb begin
      wait_cnt_nxt_s = wait_cnt_r;
      if (accept_s || !s_valid_i) begin
         wait_cnt_nxt_s = '0;
      end else if ((state_r == ST_IDLE) && !rdy_s && (wait_cnt_r != '1)) begin
         wait_cnt_nxt_s = wait_cnt_r + TIMEOUT_W'(1);
      end else begin
         wait_cnt_nxt_s = wait_cnt_r;
      end
   end

   // Watchdog counter and sticky flag; only a reset clears the flag.
   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         wait_cnt_r <= '0;
         timeout_o  <= 1'b0;
      end else begin
         wait_cnt_r <= wait_cnt_nxt_s;
         timeout_o  <= timeout_o | (wait_cnt_nxt_s == '1);
      end
   end
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_blake2_bus_host.sv
// Self-checking bench for blake2_bus_host: directed scenarios plus randomized
// traffic, checked every cycle against a timeline-based reference model.
module tb_blake2_bus_host;

   localparam int GAP    = 4;
   localparam int HB     = 32;
   localparam int TMO_W  = 4;
   localparam int TMO_MAX = (1 << TMO_W) - 1;

   logic       clk = 1'b0;
   logic       rst_async = 1'b1;
   logic       s_valid_i = 1'b0;
   logic       s_ready_o;
   logic [1:0] s_cmd_i = 2'b00;
   logic [7:0] s_data_i = 8'h00;
   logic [1:0] loopback_i = 2'b00;
   logic [7:0] data_o;
   logic [2:0] data_ctrl_o;
   logic [1:0] loopback_ctrl_o;
   logic [7:0] hash_i = 8'h00;
   logic [1:0] hash_ctrl_i = 2'b00;
   logic       m_valid_o;
   logic [7:0] m_data_o;
   logic       m_last_o;
   logic       short_hash_o;
   logic       busy_o;
   logic       timeout_o;

   blake2_bus_host #(
      .GAP_CYCLES (GAP),
      .HASH_BYTES (HB),
      .TIMEOUT_W  (TMO_W)
   ) dut (
      .clk             (clk),
      .rst_async       (rst_async),
      .s_valid_i       (s_valid_i),
      .s_ready_o       (s_ready_o),
      .s_cmd_i         (s_cmd_i),
      .s_data_i        (s_data_i),
      .loopback_i      (loopback_i),
      .data_o          (data_o),
      .data_ctrl_o     (data_ctrl_o),
      .loopback_ctrl_o (loopback_ctrl_o),
      .hash_i          (hash_i),
      .hash_ctrl_i     (hash_ctrl_i),
      .m_valid_o       (m_valid_o),
      .m_data_o        (m_data_o),
      .m_last_o        (m_last_o),
      .short_hash_o    (short_hash_o),
      .busy_o          (busy_o),
      .timeout_o       (timeout_o)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state: pin history indexed by clock edge number
   int       n = 2;
   bit       rdy_h  [0:8191];
   bit       hv_h   [0:8191];
   bit [7:0] hash_h [0:8191];
   bit       have_acc = 1'b0;
   int       a = 0;
   bit [1:0] acc_cmd = 2'b00;
   bit [7:0] acc_data = 8'h00;
   bit       acc_now = 1'b0;
   int       pos = 0;
   int       wcnt = 0;
   bit       tmo = 1'b0;
   bit [1:0] e_lb = 2'b00;
   bit       e_mv = 1'b0;
   bit [7:0] e_md = 8'h00;
   bit       e_ml = 1'b0;
   bit       e_sh = 1'b0;
   int       sr_cnt = 0;
   int       mv_cnt = 0;
   int       ml_cnt = 0;
   int       sh_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Transmitter is idle once GAP+1 edges have passed since the last accept.
   function automatic bit tx_idle();
      return !have_acc || ((n - a) >= (GAP + 1));
   endfunction

   task automatic clear_model();
      rdy_h[n] = 1'b0; rdy_h[n-1] = 1'b0;
      hv_h[n]  = 1'b0; hv_h[n-1]  = 1'b0;
      have_acc = 1'b0; pos = 0; wcnt = 0; tmo = 1'b0;
      e_lb = 2'b00; e_mv = 1'b0; e_ml = 1'b0; e_sh = 1'b0;
   endtask

   // One clock cycle: check s_ready before the edge, advance the model, check outputs after.
   task automatic cycle();
      bit exp_sr, idle_b, rdy_b, v;
      bit e_busy;
      logic [2:0] e_dc;
      logic [7:0] e_do;
      logic e_to;
      #1;
      idle_b = tx_idle();
      rdy_b  = rdy_h[n-1];
      exp_sr = idle_b && s_valid_i && rdy_b;
      chk("s_ready", {31'd0, s_ready_o}, {31'd0, exp_sr});
      if (s_ready_o) sr_cnt++;
      acc_now = 1'b0;
      @(posedge clk);
      n++;
      if (rst_async) begin
         rdy_h[n] = 1'b0; hv_h[n] = 1'b0; hash_h[n] = 8'h00;
         clear_model();
      end else begin
         rdy_h[n] = hash_ctrl_i[0]; hv_h[n] = hash_ctrl_i[1]; hash_h[n] = hash_i;
         e_lb = loopback_i;
         if (exp_sr) begin
            if (have_acc) chk("acc_spacing", {31'd0, ((n - a) >= (GAP + 2))}, 32'd1);
            have_acc = 1'b1; a = n; acc_cmd = s_cmd_i; acc_data = s_data_i; acc_now = 1'b1;
         end
         if (exp_sr || !s_valid_i) wcnt = 0;
         else if (idle_b && !rdy_b && wcnt != TMO_MAX) wcnt++;
         if (wcnt == TMO_MAX) tmo = 1'b1;
         v = hv_h[n-2];
         e_mv = v; e_md = hash_h[n-2];
         if (v) begin
            pos++; e_sh = 1'b0; e_ml = (pos == HB);
            if (e_ml) pos = 0;
         end else begin
            e_ml = 1'b0; e_sh = (pos != 0); pos = 0;
         end
      end
      @(negedge clk);
      e_busy = have_acc && ((n - a) < (GAP + 1));
      e_dc   = have_acc ? {acc_cmd, (n == a)} : 3'b000;
      e_do   = have_acc ? acc_data : 8'h00;
`ifdef BLAKE2_BUS_HOST_TIMEOUT_EN
      e_to = tmo;
`else
      e_to = 1'b0;
`endif
      chk("data_o", {24'd0, data_o}, {24'd0, e_do});
      chk("data_ctrl", {29'd0, data_ctrl_o}, {29'd0, e_dc});
      chk("busy", {31'd0, busy_o}, {31'd0, e_busy});
      chk("loopback", {30'd0, loopback_ctrl_o}, {30'd0, e_lb});
      chk("m_valid", {31'd0, m_valid_o}, {31'd0, e_mv});
      if (e_mv) chk("m_data", {24'd0, m_data_o}, {24'd0, e_md});
      chk("m_last", {31'd0, m_last_o}, {31'd0, e_ml});
      chk("short_hash", {31'd0, short_hash_o}, {31'd0, e_sh});
      chk("timeout", {31'd0, timeout_o}, {31'd0, e_to});
      if (m_valid_o) mv_cnt++;
      if (m_last_o) ml_cnt++;
      if (short_hash_o) sh_cnt++;
   endtask

   // Assert reset part-way through a cycle, hold it for some edges, release at a negedge.
   task automatic do_reset(input int hold);
      #2;
      rst_async = 1'b1;
      #1;
      chk("rst_async_dc", {29'd0, data_ctrl_o}, 32'd0);
      chk("rst_async_mv", {31'd0, m_valid_o}, 32'd0);
      clear_model();
      repeat (hold) cycle();
      rst_async = 1'b0;
   endtask

   task automatic reset_counts();
      sr_cnt = 0; mv_cnt = 0; ml_cnt = 0; sh_cnt = 0;
   endtask

   initial begin
      int got;
      // Reset state
      #1;
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_dc", {29'd0, data_ctrl_o}, 32'd0);
      chk("rst_lb", {30'd0, loopback_ctrl_o}, 32'd0);
      repeat (3) cycle();
      rst_async = 1'b0;

      // Single byte with ready held high
      hash_ctrl_i = 2'b01;
      repeat (4) cycle();
      s_valid_i = 1'b1; s_cmd_i = 2'b10; s_data_i = 8'hA5;
      cycle();
      chk("single_acc", {31'd0, acc_now}, 32'd1);
      chk("single_data", {24'd0, data_o}, 32'h0000_00A5);
      chk("single_dc_drive", {29'd0, data_ctrl_o}, 32'd5);
      s_data_i = 8'h3C;
      cycle();
      chk("single_dc_gap", {29'd0, data_ctrl_o}, 32'd4);
      got = 1;
      while (!acc_now && got < 20) begin
         cycle();
         got++;
      end
      chk("second_acc_dist", got, 32'd6);
      s_valid_i = 1'b0;
      repeat (8) cycle();

      // Ready low while a byte waits
      hash_ctrl_i = 2'b00;
      repeat (8) cycle();
      reset_counts();
      s_valid_i = 1'b1; s_data_i = 8'h5A; s_cmd_i = 2'b01;
      repeat (20) cycle();
      chk("ready_low_no_acc", sr_cnt, 32'd0);
`ifdef BLAKE2_BUS_HOST_TIMEOUT_EN
      chk("timeout_set", {31'd0, timeout_o}, 32'd1);
`else
      chk("timeout_tied", {31'd0, timeout_o}, 32'd0);
`endif
      hash_ctrl_i = 2'b01;
      cycle();
      cycle();
      #1;
      chk("ready_sync_lat", {31'd0, s_ready_o}, 32'd1);
      repeat (20) cycle();
      s_valid_i = 1'b0;
      repeat (8) cycle();

      // Full 32-byte frame
      reset_counts();
      for (int i = 0; i < HB; i++) begin
         hash_i = 8'(i); hash_ctrl_i = 2'b11;
         cycle();
         if (i == 1) chk("frame_lat_pre", {31'd0, m_valid_o}, 32'd0);
         if (i == 2) chk("frame_lat", {23'd0, m_valid_o, m_data_o}, 32'h0000_0100);
      end
      hash_ctrl_i = 2'b01;
      repeat (6) cycle();
      chk("frame_beats", mv_cnt, 32'd32);
      chk("frame_last", ml_cnt, 32'd1);
      chk("frame_short", sh_cnt, 32'd0);

      // Short frame followed by a full frame
      reset_counts();
      for (int i = 0; i < 10; i++) begin
         hash_i = 8'(8'hC0 + i); hash_ctrl_i = 2'b11;
         cycle();
      end
      hash_ctrl_i = 2'b01;
      repeat (6) cycle();
      chk("short_beats", mv_cnt, 32'd10);
      chk("short_pulse", sh_cnt, 32'd1);
      chk("short_no_last", ml_cnt, 32'd0);
      reset_counts();
      for (int i = 0; i < 2 * HB; i++) begin
         hash_i = 8'($urandom); hash_ctrl_i = 2'b11;
         cycle();
      end
      hash_ctrl_i = 2'b01;
      repeat (6) cycle();
      chk("double_frame_last", ml_cnt, 32'd2);
      chk("double_frame_short", sh_cnt, 32'd0);

      // Reset during DRIVE
      loopback_i = 2'b11;
      s_valid_i = 1'b1; s_cmd_i = 2'b11; s_data_i = 8'h77;
      got = 0;
      while (!acc_now && got < 20) begin
         cycle();
         got++;
      end
      chk("rst_send_acc", {31'd0, acc_now}, 32'd1);
      s_valid_i = 1'b0;
      do_reset(2);
      cycle();
      chk("lb_after_rst", {30'd0, loopback_ctrl_o}, 32'd3);
      chk("idle_after_rst", {31'd0, busy_o}, 32'd0);
      chk("no_resend", {29'd0, data_ctrl_o}, 32'd0);

      // Randomized traffic on both directions
      for (int i = 0; i < 1500; i++) begin
         s_valid_i  = ($urandom_range(0, 99) < 70);
         s_cmd_i    = 2'($urandom);
         s_data_i   = 8'($urandom);
         loopback_i = 2'($urandom);
         hash_i     = 8'($urandom);
         if ($urandom_range(0, 99) < 10) hash_ctrl_i[0] = ~hash_ctrl_i[0];
         if ($urandom_range(0, 99) < 4)  hash_ctrl_i[1] = ~hash_ctrl_i[1];
         if ($urandom_range(0, 499) == 0) do_reset(2);
         else cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/blake2_bus_host.md
Name: blake2_bus_host

Overview:
- FPGA-side host for the blake2 PMOD byte bus; the initiator for the emulator's `data_i`/`data_ctrl_i`/`loopback_ctrl_i` inputs, and the capture end for its `hash_o`/`hash_ctrl_o` outputs.
- Takes command/data bytes from an upstream valid/ready stream and drives them onto the bus at a safe rate, gated by the DUT's `ready`.
- Collects `hash_v`-qualified hash bytes into a framed output stream.
- Replaces the RPi PIO driver in self-contained FPGA loopback tests.

Parameters:
- `GAP_CYCLES`, default 4: idle cycles after each driven byte before `ready` is re-evaluated. Must be at least the bus round-trip (DUT 2-flop sync plus output register plus host 2-flop sync).
- `HASH_BYTES`, default 32: bytes per hash frame.
- `TIMEOUT_W`, default 16: width of the ready-wait watchdog counter (optional feature only).

Ports:
- `clk` in 1: bus clock, same source as the DUT.
- `rst_async` in 1: asynchronous reset, active-high.
- `s_valid_i` in 1: upstream byte valid.
- `s_ready_o` out 1: upstream byte accepted this cycle.
- `s_cmd_i` in 2: command code sent with the byte (opaque, passed through).
- `s_data_i` in 8: byte to send.
- `loopback_i` in 2: loopback mode request.
- `data_o` out 8: bus data byte (to DUT `data_i`).
- `data_ctrl_o` out 3: `[0]` = valid, `[2:1]` = cmd (to DUT `data_ctrl_i`).
- `loopback_ctrl_o` out 2: registered `loopback_i` (to DUT `loopback_ctrl_i`).
- `hash_i` in 8: bus hash byte (from DUT `hash_o`).
- `hash_ctrl_i` in 2: `[1]` = hash_v, `[0]` = ready (from DUT `hash_ctrl_o`).
- `m_valid_o` out 1: captured hash byte valid.
- `m_data_o` out 8: captured hash byte.
- `m_last_o` out 1: final byte of the hash frame.
- `short_hash_o` out 1: one-cycle pulse when hash_v falls mid-frame.
- `busy_o` out 1: transmit FSM not in IDLE.
- `timeout_o` out 1: sticky ready-wait watchdog flag.

Behaviour:
- **Reset.** All outputs 0; FSM in IDLE; synchronisers cleared; frame index 0; gap counter 0. Reset asserted mid-transfer aborts immediately. `data_ctrl_o[0]` drops asynchronously; no partial byte is resent after reset.
- **Input sync.** `hash_i` and `hash_ctrl_i` pass through 2 flops each. `rdy_s` and `hv_s` denote the synced `ready` and `hash_v` bits.
- **Transmit FSM** (states IDLE, DRIVE, GAP):
  - IDLE: when `s_valid_i` and `rdy_s`, assert `s_ready_o` combinationally for that cycle. Register `s_data_i` to `data_o` and `{s_cmd_i, 1'b1}` to `data_ctrl_o`; go to DRIVE. Otherwise `s_ready_o` is 0.
  - DRIVE: exactly one cycle with `data_ctrl_o[0]` = 1. Next cycle clear `data_ctrl_o[0]`, keep `data_o` and cmd bits held, load the gap counter with `GAP_CYCLES-1`, go to GAP.
  - GAP: decrement each cycle; at 0 return to IDLE. `s_ready_o` is 0 throughout.
  - Maximum throughput is one byte per `GAP_CYCLES+2` cycles. `rdy_s` dropping during DRIVE or GAP does not cancel the in-flight byte.
- **Loopback.** `loopback_ctrl_o` is `loopback_i` registered once, updated every cycle, independent of the FSM.
- **Hash capture.**
  - Each cycle with `hv_s` = 1 produces one output byte: `m_valid_o` = 1 and `m_data_o` = synced `hash_i`, both registered. Latency from DUT pins to `m_valid_o` is 3 cycles.
  - There is no backpressure; the consumer accepts every cycle.
  - The frame index counts 0..`HASH_BYTES-1`. `m_last_o` = 1 together with the byte at index `HASH_BYTES-1`, after which the index wraps to 0.
  - If `hv_s` stays high past the last byte, a new frame starts at index 0.
  - If `hv_s` falls while the index is not 0: pulse `short_hash_o` for one cycle and reset the index to 0; no `m_last_o` is emitted.
- **Simultaneous events.** Transmit and capture are independent and may be active in the same cycle.

Optional Feature:
- **Macro:** `BLAKE2_BUS_HOST_TIMEOUT_EN`.
- **With the macro defined:**
  - A `TIMEOUT_W`-bit counter increments each cycle the FSM is in IDLE with `s_valid_i` = 1 and `rdy_s` = 0.
  - It clears to 0 on any accept, or when `s_valid_i` = 0.
  - At all-ones it sets `timeout_o`, which stays set until `rst_async`. Transmission continues normally after the flag is set.
- **Without the macro:** `timeout_o` is tied to 0 and no counter is synthesised.

Test Plan:
- **Single byte.** Hold `hash_ctrl_i` = 2'b01, then present `s_cmd_i` = 2'b10 with `s_data_i` = 8'hA5 → `s_ready_o` pulses 1 cycle. Next cycle `data_o` = A5 and `data_ctrl_o` = 3'b101 for exactly 1 cycle, then 3'b100. Next accept is no earlier than 6 cycles after the first with `GAP_CYCLES` = 4.
- **Ready low.** Keep `hash_ctrl_i[0]` = 0 with `s_valid_i` = 1 for 20 cycles → no `s_ready_o`, `data_ctrl_o[0]` stays 0. Raise ready → accept occurs 2 cycles later (sync delay).
- **Full frame.** Drive `hash_ctrl_i[1]` = 1 for 32 cycles with `hash_i` = 0..31 → 32 `m_valid_o` beats with `m_data_o` = 0..31, first beat 3 cycles after the first pin byte. `m_last_o` is high only with byte 31.
- **Short frame.** Hold hash_v for 10 cycles, then drop it → 10 bytes out, `short_hash_o` pulses once, no `m_last_o`. A following 32-byte frame starts at index 0.
- **Reset mid-send.** Assert `rst_async` during DRIVE → `data_ctrl_o` = 0 immediately and the FSM is in IDLE after release. The loopback pattern 2'b11 reappears on `loopback_ctrl_o` 1 cycle after release.
- **Timeout (macro on, `TIMEOUT_W` = 4).** Hold `s_valid_i` = 1 with ready low → `timeout_o` rises after 15 waiting cycles and remains 1 after ready returns and bytes flow.
